// File: rtl/adiabatic_pclk_sequencer.sv
// Four-phase trapezoidal power-clock sequencer for adiabatic gate pipelines.
// Outputs are registered decodes of the next-state counters, so they align with the state registers with no extra cycle of lag.
module adiabatic_pclk_sequencer #(
  parameter int RAMP_LEN = 8,
  parameter int LVL_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  output logic [4*LVL_W-1:0] lvl_pos,
  output logic [4*LVL_W-1:0] lvl_neg,
  output logic [3:0]         hold,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycles
);

  localparam int CW = (RAMP_LEN > 2) ? $clog2(RAMP_LEN) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(RAMP_LEN - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(RAMP_LEN);

  typedef enum logic [1:0] {ST_STOPPED, ST_RUN, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         q_q, q_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [3:0]         hold_q, hold_d;
  logic [4*LVL_W-1:0] lvl_pos_q, lvl_pos_d;
  logic [4*LVL_W-1:0] lvl_neg_q, lvl_neg_d;

  logic               last;
  logic [1:0]         ph_s    [4];
  logic [LVL_W-1:0]   ph_lvl  [4];
  logic               ph_live [4];

  assign last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    cycles_d = cycles_q;
    done_d   = 1'b0;
    case (state_q)
      ST_STOPPED: begin
        if (start) begin
          state_d = ST_RUN;
          q_d     = 2'd0;
          cnt_d   = '0;
          pend_d  = stop;
        end
      end
      ST_RUN: begin
        if (stop) pend_d = 1'b1;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) q_d = q_q + 2'd1;
        if (last && q_q == 2'd3) begin
          if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
          if (pend_q) begin
            state_d = ST_DRAIN;
            q_d     = 2'd0;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) q_d = q_q + 2'd1;
        if (last && q_q == 2'd2) begin
          state_d = ST_STOPPED;
          q_d     = 2'd0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Per-phase decode from the next state; in DRAIN only phases past the current quarter may finish their ramp.
  always_comb begin
    busy_d    = (state_d != ST_STOPPED);
    hold_d    = 4'b0000;
    lvl_pos_d = '0;
    lvl_neg_d = '0;
    for (int k = 0; k < 4; k++) begin
      ph_s[k] = q_d - 2'(k);
      case (ph_s[k])
        2'd0:    ph_lvl[k] = LVL_W'(cnt_d) + LVL_W'(1);
        2'd1:    ph_lvl[k] = LVL_MAX;
        2'd2:    ph_lvl[k] = LVL_MAX - LVL_W'(1) - LVL_W'(cnt_d);
        default: ph_lvl[k] = '0;
      endcase
      ph_live[k] = (state_d == ST_RUN) || ((state_d == ST_DRAIN) && (q_d < 2'(k)));
      if (!ph_live[k]) ph_lvl[k] = '0;
      hold_d[k] = ph_live[k] && (ph_s[k] == 2'd1);
      lvl_pos_d[k*LVL_W +: LVL_W] = ph_lvl[k];
      lvl_neg_d[k*LVL_W +: LVL_W] = LVL_MAX - ph_lvl[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOPPED;
      q_q       <= 2'd0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= 4'b0000;
      lvl_pos_q <= '0;
      lvl_neg_q <= {4{LVL_MAX}};
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      lvl_pos_q <= lvl_pos_d;
      lvl_neg_q <= lvl_neg_d;
    end
  end

  assign lvl_pos = lvl_pos_q;
  assign lvl_neg = lvl_neg_q;
  assign hold    = hold_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_adiabatic_pclk_sequencer.sv
// Directed bench: RAMP_LEN=4 main instance, plus a RAMP_LEN=8 / 2-bit counter instance for saturation.
module tb_adiabatic_pclk_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic        start2 = 1'b0, stop2 = 1'b0;
  logic [15:0] lvl_pos, lvl_neg, b_lvl_pos, b_lvl_neg;
  logic [3:0]  hold, b_hold;
  logic        busy, done, b_busy, b_done;
  logic [15:0] cycles;
  logic [1:0]  b_cycles;

  int checks = 0;
  int failures = 0;
  int exp0 [16] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0, 0, 0, 0};
  int ex3  [12] = '{4, 4, 4, 4, 3, 2, 1, 0, 0, 0, 0, 0};

  adiabatic_pclk_sequencer #(.RAMP_LEN(4), .LVL_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .lvl_pos(lvl_pos), .lvl_neg(lvl_neg), .hold(hold),
    .busy(busy), .done(done), .cycles(cycles)
  );

  adiabatic_pclk_sequencer #(.RAMP_LEN(8), .LVL_W(4), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2),
    .lvl_pos(b_lvl_pos), .lvl_neg(b_lvl_neg), .hold(b_hold),
    .busy(b_busy), .done(b_done), .cycles(b_cycles)
  );

  always #5 clk = ~clk;

  function automatic int fld(input logic [15:0] v, input int k);
    return int'(v[k*4 +: 4]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    adv(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adv(2);
    checks++; if (lvl_pos !== 16'h0000) begin failures++; $display("FAIL reset_lvl_pos got=%h exp=0000", lvl_pos); end
    checks++; if (lvl_neg !== 16'h4444) begin failures++; $display("FAIL reset_lvl_neg got=%h exp=4444", lvl_neg); end
    checks++; if (b_lvl_neg !== 16'h8888) begin failures++; $display("FAIL reset_lvl_neg8 got=%h exp=8888", b_lvl_neg); end
    checks++; if (hold !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags got hold=%h busy=%b done=%b exp 0/0/0", hold, busy, done); end
    checks++; if (cycles !== 16'd0 || b_cycles !== 2'd0) begin failures++; $display("FAIL reset_cycles got=%0d/%0d exp=0/0", cycles, b_cycles); end
    // Mid-stream: one full cycle then into quarter 1, then asynchronous reset between edges.
    rst = 1'b0;
    tick();
    pulse_start();
    adv(21);
    checks++; if (cycles !== 16'd1 || busy !== 1'b1 || fld(lvl_pos, 1) !== 2) begin failures++; $display("FAIL pre_reset_run got cycles=%0d busy=%b ph1=%0d exp 1/1/2", cycles, busy, fld(lvl_pos, 1)); end
    #2 rst = 1'b1;
    #1;
    checks++; if (lvl_pos !== 16'h0000 || lvl_neg !== 16'h4444) begin failures++; $display("FAIL async_reset_lvl got pos=%h neg=%h exp 0000/4444", lvl_pos, lvl_neg); end
    checks++; if (hold !== 4'h0 || busy !== 1'b0 || cycles !== 16'd0 || done !== 1'b0) begin failures++; $display("FAIL async_reset_flags got hold=%h busy=%b cyc=%0d done=%b exp 0/0/0/0", hold, busy, cycles, done); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle got done=%b busy=%b exp 0/0", done, busy); end
    end
  endtask

  task automatic test_ramp();
    int e1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      e1 = (i < 4) ? 0 : exp0[(i - 4) % 16];
      checks++; if (fld(lvl_pos, 0) !== exp0[i % 16]) begin failures++; $display("FAIL ramp_ph0 i=%0d got=%0d exp=%0d", i, fld(lvl_pos, 0), exp0[i % 16]); end
      checks++; if (fld(lvl_neg, 0) !== 4 - exp0[i % 16]) begin failures++; $display("FAIL ramp_neg0 i=%0d got=%0d exp=%0d", i, fld(lvl_neg, 0), 4 - exp0[i % 16]); end
      checks++; if (fld(lvl_pos, 1) !== e1) begin failures++; $display("FAIL ramp_ph1 i=%0d got=%0d exp=%0d", i, fld(lvl_pos, 1), e1); end
      checks++; if (hold[0] !== ((i % 16) >= 4 && (i % 16) < 8)) begin failures++; $display("FAIL ramp_hold0 i=%0d got=%b", i, hold[0]); end
      tick();
    end
  endtask

  task automatic test_drain();
    int e2;
    do_reset();
    pulse_start();
    adv(36);
    pulse_stop();
    adv(11);
    checks++; if (cycles !== 16'd3 || busy !== 1'b1) begin failures++; $display("FAIL drain_entry got cycles=%0d busy=%b exp 3/1", cycles, busy); end
    for (int j = 0; j < 12; j++) begin
      e2 = (j < 4) ? 3 - j : 0;
      checks++; if (fld(lvl_pos, 3) !== ex3[j]) begin failures++; $display("FAIL drain_ph3 j=%0d got=%0d exp=%0d", j, fld(lvl_pos, 3), ex3[j]); end
      checks++; if (fld(lvl_pos, 2) !== e2) begin failures++; $display("FAIL drain_ph2 j=%0d got=%0d exp=%0d", j, fld(lvl_pos, 2), e2); end
      checks++; if (lvl_pos[7:0] !== 8'h00 || hold[1:0] !== 2'b00) begin failures++; $display("FAIL drain_ph01 j=%0d got=%h hold=%b exp 00/00", j, lvl_pos[7:0], hold[1:0]); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL drain_busy j=%0d got busy=%b done=%b exp 1/0", j, busy, done); end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || lvl_pos !== 16'h0000) begin failures++; $display("FAIL drain_done got done=%b busy=%b pos=%h exp 1/0/0000", done, busy, lvl_pos); end
    checks++; if (cycles !== 16'd3) begin failures++; $display("FAIL drain_cycles got=%0d exp=3", cycles); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_start_stop_same();
    do_reset();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int j = 0; j < 28; j++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL same_busy j=%0d got busy=%b done=%b exp 1/0", j, busy, done); end
      if (j == 16) begin
        checks++; if (cycles !== 16'd1 || fld(lvl_pos, 0) !== 0) begin failures++; $display("FAIL same_one_cycle got cycles=%0d ph0=%0d exp 1/0", cycles, fld(lvl_pos, 0)); end
      end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cycles !== 16'd1) begin failures++; $display("FAIL same_done got done=%b busy=%b cyc=%0d exp 1/0/1", done, busy, cycles); end
  endtask

  task automatic test_ignored();
    do_reset();
    pulse_stop();
    for (int i = 0; i < 3; i++) begin
      checks++; if (lvl_pos !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL stop_idle got pos=%h busy=%b done=%b exp 0000/0/0", lvl_pos, busy, done); end
      tick();
    end
    pulse_start();
    adv(6);
    pulse_start();
    checks++; if (fld(lvl_pos, 0) !== exp0[7] || hold[0] !== 1'b1) begin failures++; $display("FAIL start_in_run got ph0=%0d hold0=%b exp %0d/1", fld(lvl_pos, 0), hold[0], exp0[7]); end
    adv(3);
    checks++; if (fld(lvl_pos, 0) !== exp0[10]) begin failures++; $display("FAIL start_in_run2 got ph0=%0d exp=%0d", fld(lvl_pos, 0), exp0[10]); end
    adv(10);
    pulse_stop();
    adv(3);
    pulse_stop();
    adv(9);
    pulse_start();
    checks++; if (fld(lvl_pos, 3) !== ex3[3] || fld(lvl_pos, 0) !== 0) begin failures++; $display("FAIL start_in_drain got ph3=%0d ph0=%0d exp %0d/0", fld(lvl_pos, 3), fld(lvl_pos, 0), ex3[3]); end
    adv(9);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cycles !== 16'd2) begin failures++; $display("FAIL double_stop_done got done=%b busy=%b cyc=%0d exp 1/0/2", done, busy, cycles); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL after_drain_idle i=%0d got done=%b busy=%b exp 0/0", i, done, busy); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    start2 = 1'b1; tick(); start2 = 1'b0;
    adv(64);
    checks++; if (b_cycles !== 2'd2) begin failures++; $display("FAIL sat_two got=%0d exp=2", b_cycles); end
    adv(32);
    checks++; if (b_cycles !== 2'd3) begin failures++; $display("FAIL sat_three got=%0d exp=3", b_cycles); end
    adv(64);
    checks++; if (b_cycles !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", b_cycles); end
  endtask

  task automatic test_stress();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 14) == 0);
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++; if (fld(lvl_pos, k) + fld(lvl_neg, k) !== 4) begin failures++; $display("FAIL stress_sum c=%0d k=%0d got=%0d exp=4", c, k, fld(lvl_pos, k) + fld(lvl_neg, k)); end
        if (hold[k]) begin
          checks++; if (fld(lvl_pos, k) !== 4) begin failures++; $display("FAIL stress_hold c=%0d k=%0d got=%0d exp=4", c, k, fld(lvl_pos, k)); end
        end
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_drain();
    test_start_stop_same();
    test_ignored();
    test_saturate();
    test_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adiabatic_pclk_sequencer.md
Name: adiabatic_pclk_sequencer

Overview:
- Digital controller that sequences the four-phase trapezoidal power clocks (clkpos/clkneg) feeding a pipeline of adiabatic gates such as nor4b stages.
- Each phase steps through RAMP_UP, HOLD, RAMP_DOWN and IDLE, 90° apart from its neighbour, and emits a DAC level code for the power-clock driver plus a per-phase "data valid" flag.
- Provides start/stop control. Stop is clean: every phase returns to 0 and no ramp is truncated before the sequencer parks.

Parameters:
- RAMP_LEN, 8, cycles per quarter; level steps per ramp (≥2).
- LVL_W, 4, level code width; must hold RAMP_LEN.
- CNT_W, 16, width of completed-cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; begin sequencing
- stop  in  1  single-cycle pulse; request clean stop
- lvl_pos  out  4*LVL_W  clkpos level code per phase; phase k at [k*LVL_W +: LVL_W]
- lvl_neg  out  4*LVL_W  clkneg code per phase, equal to RAMP_LEN − lvl_pos, per field
- hold  out  4  phase k is in HOLD (stage outputs valid)
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse on DRAIN→STOPPED
- cycles  out  CNT_W  completed full power-clock cycles, saturating

Behaviour:
- State: top FSM {STOPPED, RUN, DRAIN}, quarter counter q (2b), step counter cnt (0..RAMP_LEN-1), stop_pending flag, cycles counter.
- All outputs are decoded from registers; no extra latency.
- Reset (asynchronous) values:
  - FSM=STOPPED, q=0, cnt=0, stop_pending=0, cycles=0.
  - lvl_pos=0, lvl_neg=all fields RAMP_LEN, hold=0, busy=0, done=0.
- Phase k state index s=(q−k) mod 4: 0 RAMP_UP, 1 HOLD, 2 RAMP_DOWN, 3 IDLE.
- Phase k level:
  - RAMP_UP: cnt+1
  - HOLD: RAMP_LEN
  - RAMP_DOWN: RAMP_LEN−1−cnt
  - IDLE: 0
- hold[k]=1 only when phase k is in HOLD and the phase is not forced idle.
- STOPPED:
  - All phases are at level 0.
  - On start, the next cycle is RUN with q=0, cnt=0, so lvl_pos phase0=1 in that cycle.
  - stop alone is ignored.
  - start and stop in the same cycle: enter RUN with stop_pending=1; exactly one full cycle runs, then DRAIN.
- RUN:
  - cnt increments each clk. At cnt=RAMP_LEN−1, cnt←0 and q←q+1 mod 4.
  - At q=3, cnt=last: cycles increments (saturates at all-ones). If stop_pending, go to DRAIN with q=0, cnt=0, and clear stop_pending.
  - A stop pulse sets stop_pending. start is ignored.
- DRAIN:
  - Counters advance as in RUN for quarters q=0..2.
  - Phase k outputs its computed level only if q<k, otherwise level 0 and hold=0. Phase0 is always 0.
  - Net effect: phase1 idle; phase2 finishes RAMP_DOWN; phase3 finishes HOLD then RAMP_DOWN; no new RAMP_UP starts.
  - At q=2, cnt=last: go to STOPPED, q=0, and assert done for 1 cycle (the first STOPPED cycle).
  - start and stop are ignored; cycles does not change.
- Reset mid-operation: outputs drop to 0 immediately (asynchronous); no done pulse.
- Invariant: lvl_pos+lvl_neg=RAMP_LEN per field, at all times.

Test Plan:
- Reset → all lvl_pos fields 0, lvl_neg fields 8, hold=0, busy=0, cycles=0, checked mid-stream too. Reset during RUN q=1 gives the same values asynchronously.
- RAMP_LEN=4, start at edge t:
  - Phase0 lvl_pos t+1..t+16 = 1,2,3,4,4,4,4,4,3,2,1,0,0,0,0,0.
  - Phase1 is the same sequence delayed 4 cycles.
  - hold[0] high t+5..t+8.
- RAMP_LEN=4, run 3 cycles then stop in cycle 3:
  - cycles=3.
  - Drain lasts 12 cycles: phase3 shows 4,4,4,4,3,2,1,0,0,0,0,0; phases 0/1 stay 0; phase2 shows 3,2,1,0 then 0.
  - done pulses once, busy drops with it.
- start and stop in same cycle → exactly one cycle (16 clk, cycles=1), then 12-clk drain, then done.
- start during RUN/DRAIN and stop while STOPPED → no change in any output. Second stop in RUN → still one drain.
- Force cycles to all-ones−1, run 2 cycles → cycles saturates at all-ones. Random start/stop stress with lvl_pos+lvl_neg=RAMP_LEN assertion.
